// File: rtl/cpu_reset_ctrl.sv
// rtl/cpu_reset_ctrl.sv - reset sequencer for the CPU PLL and W65C02 RESB
//
// Purpose:
//   Holds the CPU PLL in reset, waits for lock, then holds cpu_resb low long
//   enough for the 6502 reset sequence. A debounced button press or a loss of
//   PLL lock restarts the sequence. A lock timeout retries the PLL reset.
//
// Ports:
//   clk_50          in   system clock, 50 MHz
//   reset           in   asynchronous, active-high global reset
//   button_reset    in   raw push button, active-low, asynchronous, bouncy
//   pll_cpu_locked  in   CPU PLL lock indicator, asynchronous to clk_50
//   pll_cpu_reset   out  PLL reset, active-low (0 = PLL held in reset)
//   cpu_resb        out  6502 RESB, active-low, registered
//   seq_busy        out  1 whenever the sequencer is not in RUN
//   reset_cause     out  [1:0] last restart cause (only with RESET_CAUSE_EN):
//                        00 power-on, 01 button, 10 lock loss, 11 lock timeout
//
// Configuration macro: RESET_CAUSE_EN adds the reset_cause output.

module cpu_reset_ctrl #(
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned RES_HOLD_CYCLES = 64,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       button_reset,
    input  logic       pll_cpu_locked,
    output logic       pll_cpu_reset,
    output logic       cpu_resb,
    output logic       seq_busy
`ifdef RESET_CAUSE_EN
    ,
    output logic [1:0] reset_cause
`endif
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (RES_HOLD_CYCLES > DEBOUNCE_CYCLES) ? RES_HOLD_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RES_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic          lock_meta, locked_sync;
    logic          btn_meta, btn_sync;
    logic          btn_db;
    logic [CW-1:0] db_cnt;
    logic          press;

    // The button synchronizer clears to the released level so that leaving
    // reset never looks like a press to the debouncer.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            lock_meta   <= 1'b0;
            locked_sync <= 1'b0;
            btn_meta    <= 1'b1;
            btn_sync    <= 1'b1;
        end else begin
            lock_meta   <= pll_cpu_locked;
            locked_sync <= lock_meta;
            btn_meta    <= button_reset;
            btn_sync    <= btn_meta;
        end
    end

    // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
    // cycles of the synced level differing from the accepted level.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_sync == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
        end else if (db_cnt != '1) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign press = ~btn_db;

    always_comb begin
        state_next = state;
        case (state)
            PLL_RST: begin
                if (cnt == PLL_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_sync)            state_next = HOLD;
                else if (cnt == LOCK_LAST)  state_next = PLL_RST;
            end
            HOLD: begin
                if (!locked_sync)                    state_next = WAIT_LOCK;
                else if (!press && cnt == HOLD_LAST) state_next = RUN;
            end
            RUN: begin
                // Press wins over lock loss here; both leave cpu_resb low.
                if (press)             state_next = HOLD;
                else if (!locked_sync) state_next = WAIT_LOCK;
            end
            default: state_next = PLL_RST;
        endcase
    end

    // One counter serves every state; it restarts on each state entry and
    // is pinned at zero in HOLD while the button is down, so the RESB pulse
    // is always at least RES_HOLD_CYCLES after release.
    always_comb begin
        cnt_next = cnt;
        if (state_next != state)            cnt_next = '0;
        else if (state == HOLD && press)    cnt_next = '0;
        else if (cnt != '1)                 cnt_next = cnt + 1'b1;
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register, with no decode glitches.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state         <= PLL_RST;
            cnt           <= '0;
            pll_cpu_reset <= 1'b0;
            cpu_resb      <= 1'b0;
            seq_busy      <= 1'b1;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pll_cpu_reset <= (state_next != PLL_RST);
            cpu_resb      <= (state_next == RUN);
            seq_busy      <= (state_next != RUN);
        end
    end

`ifdef RESET_CAUSE_EN
    logic [1:0] cause_next;

    // Only transitions triggered by a named event update the cause; lock
    // acquisition and the PLL_RST -> WAIT_LOCK step leave it unchanged.
    always_comb begin
        cause_next = reset_cause;
        case (state)
            WAIT_LOCK: if (state_next == PLL_RST)   cause_next = 2'b11;
            HOLD:      if (state_next == WAIT_LOCK) cause_next = 2'b10;
            RUN: begin
                if (state_next == HOLD)           cause_next = 2'b01;
                else if (state_next == WAIT_LOCK) cause_next = 2'b10;
            end
            default: cause_next = reset_cause;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) reset_cause <= 2'b00;
        else       reset_cause <= cause_next;
    end
`endif

endmodule
